// File: rtl/ctr_mode_engine.sv
// AES-128 CTR-mode stream engine: one iterative AES core generates the keystream, which is
// XORed with a valid/ready input stream. The next keystream block is prefetched while output waits.

module enc_aes (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] ciphertext,
    output logic         done
);
    typedef enum logic [1:0] {A_IDLE, A_RUN, A_HOLD} aes_state_t;

    aes_state_t   state, state_nx;
    logic [127:0] st_q, rk_q, rk_nx, st_nx;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic         done_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < 8; i++) begin
            r = gmul(r, r);
            if (i < 7) r = gmul(r, x);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] w, t, n0, n1, n2, n3;
        w  = {rk[23:0], rk[31:24]};
        t  = {sbox(w[31:24]) ^ rcon, sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] a, b, m;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned i = 0; i < 16; i++)
            a[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                b[127-8*(4*c+r) -: 8] = a[127-8*(4*((c+r)%4)+r) -: 8];
        m = b;
        if (!last) begin
            for (int unsigned c = 0; c < 4; c++) begin
                a0 = b[127-32*c -: 8];
                a1 = b[119-32*c -: 8];
                a2 = b[111-32*c -: 8];
                a3 = b[103-32*c -: 8];
                m[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                m[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                m[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                m[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return m ^ rk;
    endfunction

    always_comb begin
        rk_nx    = key_expand(rk_q, rcon_q);
        st_nx    = aes_round(st_q, rk_nx, round_q == 4'd10);
        state_nx = state;
        case (state)
            A_IDLE:  if (enable) state_nx = A_RUN;
            A_RUN:   if (round_q == 4'd10) state_nx = A_HOLD;
            A_HOLD:  if (!enable) state_nx = A_IDLE;
            default: state_nx = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= A_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= '0;
            rk_q    <= '0;
            rcon_q  <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == A_IDLE && enable) begin
                st_q    <= plaintext ^ key;
                rk_q    <= key;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
            end else if (state == A_RUN) begin
                st_q    <= st_nx;
                rk_q    <= rk_nx;
                rcon_q  <= xtime(rcon_q);
                round_q <= round_q + 4'd1;
                if (round_q == 4'd10) done_q <= 1'b1;
            end
        end
    end

    assign ciphertext = st_q;
    assign done       = done_q;
endmodule

module ctr_mode_engine #(
    parameter int CTR_W = 32,
    parameter int BLK_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [127:0]     key,
    input  logic [127:0]     iv,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [127:0]     din,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [127:0]     dout,
    output logic             busy,
    output logic             done,
    output logic             ctr_wrap
);
    typedef enum logic [1:0] {IDLE, GEN, KS, DRAIN} state_t;

    localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? '1 : ((128'd1 << CTR_W) - 128'd1);

    state_t           state, state_nx;
    logic [127:0]     key_q, ctr_q, ks_q, dout_q, ctr_sum, ctr_inc, aes_ct;
    logic [BLK_W-1:0] rem_q;
    logic             dout_valid_q, busy_q, done_q, wrap_q, aes_en, aes_done;
    logic             din_fire, dout_fire, wrap_now;

    enc_aes u_aes (
        .clk        (CLK),
        .rst        (RST),
        .enable     (aes_en),
        .key        (key_q),
        .plaintext  (ctr_q),
        .ciphertext (aes_ct),
        .done       (aes_done)
    );

    // Only the low CTR_W bits count; the mask form also covers CTR_W == 128
    assign ctr_sum  = ctr_q + 128'd1;
    assign ctr_inc  = (ctr_sum & CTR_MASK) | (ctr_q & ~CTR_MASK);
    assign wrap_now = (ctr_sum & CTR_MASK) == '0;

    always_comb begin
        state_nx  = state;
        din_ready = 1'b0;
        case (state)
            IDLE:  if (start && num_blocks != '0) state_nx = GEN;
            GEN:   if (aes_done) state_nx = KS;
            KS: begin
                din_ready = !dout_valid_q || dout_ready;
                if (din_valid && din_ready)
                    state_nx = (rem_q == BLK_W'(1)) ? DRAIN : GEN;
            end
            DRAIN: if (dout_valid_q && dout_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign din_fire  = din_valid && din_ready;
    assign dout_fire = dout_valid_q && dout_ready;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_q        <= '0;
            ctr_q        <= '0;
            ks_q         <= '0;
            dout_q       <= '0;
            rem_q        <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wrap_q       <= 1'b0;
            aes_en       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (din_fire) begin
                dout_q       <= din ^ ks_q;
                dout_valid_q <= 1'b1;
            end else if (dout_fire) begin
                dout_valid_q <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    key_q  <= key;
                    ctr_q  <= iv;
                    rem_q  <= num_blocks;
                    wrap_q <= 1'b0;
                    if (num_blocks != '0) begin
                        busy_q <= 1'b1;
                        aes_en <= 1'b1;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                GEN: if (aes_done) begin
                    ks_q   <= aes_ct;
                    aes_en <= 1'b0;
                end
                // Enable was low throughout KS, so re-raising it here launches the prefetch
                KS: if (din_fire) begin
                    ctr_q <= ctr_inc;
                    rem_q <= rem_q - BLK_W'(1);
                    if (wrap_now) wrap_q <= 1'b1;
                    if (rem_q != BLK_W'(1)) aes_en <= 1'b1;
                end
                DRAIN: if (dout_fire) begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ctr_wrap   = wrap_q;
endmodule

// File: tb/tb_ctr_mode_engine.sv
// Directed bench for ctr_mode_engine using the NIST SP800-38A F.5.1 AES-128 CTR vectors.

module tb_ctr_mode_engine;
    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV_W = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    localparam logic [127:0] PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] PT4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] CT1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CT2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] CT3  = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    localparam logic [127:0] CT4  = 128'h1e031dda2fbe03d1792170a0f3009cee;
    localparam logic [127:0] KS3  = PT3 ^ CT3;

    logic         CLK, RST, start, din_valid, din_ready, dout_valid, dout_ready;
    logic         busy, done, ctr_wrap;
    logic [127:0] key, iv, din, dout;
    logic [15:0]  num_blocks;

    int unsigned  compared = 0;
    int unsigned  failed = 0;
    int unsigned  done_cnt = 0;
    logic [127:0] out_q[$];

    ctr_mode_engine #(.CTR_W(32), .BLK_W(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .key        (key),
        .iv         (iv),
        .num_blocks (num_blocks),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .ctr_wrap   (ctr_wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!RST && dout_valid === 1'b1 && dout_ready === 1'b1) out_q.push_back(dout);
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [127:0] get_out(input int unsigned i);
        return (i < out_q.size()) ? out_q[i] : 'x;
    endfunction

    task automatic do_start(input logic [127:0] k, input logic [127:0] v, input logic [15:0] n);
        key = k; iv = v; num_blocks = n; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; key = ~k; iv = '0; num_blocks = 16'd7;
    endtask

    task automatic send_block(input logic [127:0] d, output bit ok);
        int unsigned n;
        ok = 0; n = 0;
        din = d; din_valid = 1'b1;
        while (!ok && n < 600) begin
            @(negedge CLK); ok = (din_ready === 1'b1);
            @(posedge CLK); #1; n++;
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned snap, output bit ok);
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(posedge CLK); #1;
            if (done_cnt > snap) ok = 1;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        compared++;
        if ({din_ready, dout_valid, busy, done, ctr_wrap} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags: got %b expected 00000", {din_ready, dout_valid, busy, done, ctr_wrap});
        end
        compared++;
        if (dout !== '0) begin failed++; $display("FAIL reset_dout: got %h expected 0", dout); end
        compared++;
        if (dut.aes_en !== 1'b0) begin failed++; $display("FAIL reset_aes_en: got %b expected 0", dut.aes_en); end
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_single;
        int unsigned snap; bit ok;
        out_q.delete(); snap = done_cnt;
        do_start(KEY, IV, 16'd1);
        compared++;
        if (busy !== 1'b1) begin failed++; $display("FAIL single_busy: got %b expected 1", busy); end
        send_block(PT1, ok);
        compared++;
        if (!ok) begin failed++; $display("FAIL single_din_accept: got timeout expected handshake"); end
        wait_done(snap, ok);
        repeat (3) @(posedge CLK);
        #1;
        compared++;
        if (get_out(0) !== CT1 || out_q.size() != 1) begin
            failed++; $display("FAIL single_dout: got %h (count %0d) expected %h (count 1)", get_out(0), out_q.size(), CT1);
        end
        compared++;
        if (done_cnt != snap + 1) begin failed++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - snap); end
        compared++;
        if ({busy, ctr_wrap} !== 2'b00) begin failed++; $display("FAIL single_end_flags: got %b expected 00", {busy, ctr_wrap}); end
    endtask

    task automatic run_two(input logic [127:0] v, input logic [127:0] d1, input logic [127:0] d2,
                           input logic restart, output bit ok);
        int unsigned snap; bit ok1, ok2, okd;
        out_q.delete(); snap = done_cnt;
        do_start(KEY, v, 16'd2);
        if (restart) begin
            num_blocks = 16'd1; iv = '0; start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        send_block(d1, ok1);
        send_block(d2, ok2);
        wait_done(snap, okd);
        ok = ok1 && ok2 && okd;
    endtask

    task automatic test_two_blocks;
        bit ok;
        dout_ready = 1'b1;
        run_two(IV, PT1, PT2, 1'b1, ok);
        compared++;
        if (!ok) begin failed++; $display("FAIL two_handshake: got timeout expected completion"); end
        compared++;
        if (get_out(0) !== CT1 || get_out(1) !== CT2 || out_q.size() != 2) begin
            failed++; $display("FAIL two_dout: got %h %h (count %0d) expected %h %h", get_out(0), get_out(1), out_q.size(), CT1, CT2);
        end
        compared++;
        if (dut.ctr_q !== 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01) begin
            failed++; $display("FAIL two_ctr: got %h expected f0f1f2f3f4f5f6f7f8f9fafbfcfdff01", dut.ctr_q);
        end
    endtask

    task automatic test_decrypt;
        bit ok;
        run_two(IV, CT1, CT2, 1'b0, ok);
        compared++;
        if (!ok || get_out(0) !== PT1 || get_out(1) !== PT2) begin
            failed++; $display("FAIL decrypt_dout: got %h %h expected %h %h", get_out(0), get_out(1), PT1, PT2);
        end
    endtask

    task automatic test_ctr_wrap;
        bit ok; logic [127:0] e1, e2;
        run_two(IV_W, PT1, PT2, 1'b0, ok);
        e1 = get_out(0); e2 = get_out(1);
        repeat (5) @(posedge CLK);
        #1;
        compared++;
        if (!ok || ctr_wrap !== 1'b1) begin failed++; $display("FAIL wrap_flag: got %b expected 1", ctr_wrap); end
        compared++;
        if (dut.ctr_q !== 128'hf0f1f2f3f4f5f6f7f8f9fafb00000001) begin
            failed++; $display("FAIL wrap_ctr: got %h expected f0f1f2f3f4f5f6f7f8f9fafb00000001", dut.ctr_q);
        end
        out_q.delete();
        do_start(KEY, IV_W, 16'd2);
        compared++;
        if (ctr_wrap !== 1'b0) begin failed++; $display("FAIL wrap_cleared_on_start: got %b expected 0", ctr_wrap); end
        send_block(e1, ok);
        send_block(e2, ok);
        wait_done(done_cnt, ok);
        compared++;
        if (get_out(0) !== PT1 || get_out(1) !== PT2) begin
            failed++; $display("FAIL wrap_roundtrip: got %h %h expected %h %h", get_out(0), get_out(1), PT1, PT2);
        end
    endtask

    task automatic test_zero_blocks;
        int unsigned snap;
        snap = done_cnt;
        do_start(KEY, IV, 16'd0);
        compared++;
        if ({done, busy, ctr_wrap} !== 3'b100) begin
            failed++; $display("FAIL zero_done: got done/busy/wrap %b expected 100", {done, busy, ctr_wrap});
        end
        @(posedge CLK); #1;
        compared++;
        if ({done, din_ready, dut.aes_en} !== 3'b000) begin
            failed++; $display("FAIL zero_after: got done/din_ready/aes_en %b expected 000", {done, din_ready, dut.aes_en});
        end
        @(posedge CLK); #1;
        compared++;
        if (done_cnt != snap + 1) begin failed++; $display("FAIL zero_pulses: got %0d expected 1", done_cnt - snap); end
    endtask

    task automatic test_back_to_back;
        bit ok; int unsigned stable_err, rdy_err;
        out_q.delete(); stable_err = 0; rdy_err = 0;
        dout_ready = 1'b1;
        do_start(KEY, IV, 16'd4);
        send_block(PT1, ok);
        for (int i = 0; i < 50 && out_q.size() < 1; i++) begin @(posedge CLK); #1; end
        dout_ready = 1'b0;
        send_block(PT2, ok);
        din = PT3; din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK); #1;
            if (dout !== CT2 || dout_valid !== 1'b1) stable_err++;
            if (din_ready !== 1'b0) rdy_err++;
        end
        compared++;
        if (stable_err != 0) begin failed++; $display("FAIL bp_dout_stable: got %0d bad cycles expected 0", stable_err); end
        compared++;
        if (rdy_err != 0) begin failed++; $display("FAIL bp_din_ready: got %0d ready cycles expected 0", rdy_err); end
        compared++;
        if (dut.ks_q !== KS3) begin failed++; $display("FAIL bp_prefetch: got %h expected %h", dut.ks_q, KS3); end
        compared++;
        if (out_q.size() != 1) begin failed++; $display("FAIL bp_no_dup: got %0d outputs expected 1", out_q.size()); end
        dout_ready = 1'b1;
        send_block(PT3, ok);
        send_block(PT4, ok);
        wait_done(done_cnt, ok);
        compared++;
        if (out_q.size() != 4 || get_out(0) !== CT1 || get_out(1) !== CT2 || get_out(2) !== CT3 || get_out(3) !== CT4) begin
            failed++; $display("FAIL bp_order: got %h %h %h %h (count %0d) expected %h %h %h %h",
                               get_out(0), get_out(1), get_out(2), get_out(3), out_q.size(), CT1, CT2, CT3, CT4);
        end
    endtask

    task automatic test_rst_mid_run;
        int unsigned snap;
        do_start(KEY, IV, 16'd1);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        compared++;
        if ({din_ready, dout_valid, busy, done, ctr_wrap, dut.aes_en} !== 6'b0 || dout !== '0) begin
            failed++; $display("FAIL rst_mid_outputs: got flags %b dout %h expected 0", {din_ready, dout_valid, busy, done, ctr_wrap, dut.aes_en}, dout);
        end
        RST = 1'b0;
        snap = done_cnt;
        repeat (20) @(posedge CLK);
        #1;
        compared++;
        if (done_cnt != snap || busy !== 1'b0) begin
            failed++; $display("FAIL rst_mid_quiet: got done %0d busy %b expected 0 0", done_cnt - snap, busy);
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; key = '0; iv = '0; num_blocks = '0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        test_reset();
        test_single();
        test_two_blocks();
        test_decrypt();
        test_ctr_wrap();
        test_zero_blocks();
        test_back_to_back();
        test_rst_mid_run();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
